// File: rtl/lock_monitor_pkg.sv
// rtl/lock_monitor_pkg.sv - state encoding and shared widths for the lock monitor
package lock_monitor_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    QUALIFY   = 2'd1,
    LOCKED    = 2'd2,
    LOST      = 2'd3
  } lm_state_e;

  localparam int LOST_CNT_W = 8;
  localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = '1;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lock_monitor.sv
// rtl/lock_monitor.sv - qualifies MMCM lock, counts lock losses, drives status LED
module lock_monitor
  import lock_monitor_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000,
  parameter int BLINK_HALF    = 250000
) (
  input  logic                  safe_clk,
  input  logic                  safe_reset_n,
  input  logic                  locked_async,
  input  logic                  clr_count,
  output logic                  lock_ok,
  output logic                  lost_pulse,
  output logic [LOST_CNT_W-1:0] lost_count,
  output logic                  status_led,
  output logic [1:0]            state_dbg
);

  localparam int QCNT_W = $clog2(STABLE_CYCLES);
  localparam int BCNT_W = $clog2(BLINK_HALF);
  localparam logic [QCNT_W-1:0] QCNT_LAST = QCNT_W'(STABLE_CYCLES - 1);
  localparam logic [BCNT_W-1:0] SLOW_LAST = BCNT_W'(BLINK_HALF - 1);
  localparam logic [BCNT_W-1:0] FAST_LAST = BCNT_W'(BLINK_HALF / 4 - 1);

  logic                  w_locked_s;
  lm_state_e             r_state;
  lm_state_e             w_state_nxt;
  logic                  w_loss;
  logic                  w_state_chg;
  logic                  w_blink_wrap;
  logic [LOST_CNT_W-1:0] w_cnt_base;
  logic [QCNT_W-1:0]     r_qcnt;
  logic [BCNT_W-1:0]     r_bcnt;
  logic                  r_ever_locked;
  logic                  r_lock_ok;
  logic                  r_lost_pulse;
  logic                  r_led;
  logic [LOST_CNT_W-1:0] r_lost_cnt;

  sync_2ff u_sync (
    .i_clk   (safe_clk),
    .i_rst_n (safe_reset_n),
    .i_d     (locked_async),
    .o_q     (w_locked_s)
  );

  always_ff @(posedge safe_clk or negedge safe_reset_n) begin
    if (!safe_reset_n) r_state <= WAIT_LOCK;
    else               r_state <= w_state_nxt;
  end

  // A failed qualification returns to wherever it came from and is never a loss.
  always_comb begin
    w_state_nxt = r_state;
    w_loss      = 1'b0;
    case (r_state)
      WAIT_LOCK: if (w_locked_s) w_state_nxt = QUALIFY;
      QUALIFY: begin
        if (!w_locked_s)               w_state_nxt = r_ever_locked ? LOST : WAIT_LOCK;
        else if (r_qcnt == QCNT_LAST)  w_state_nxt = LOCKED;
      end
      LOCKED: begin
        if (!w_locked_s) begin
          w_state_nxt = LOST;
          w_loss      = 1'b1;
        end
      end
      LOST:    if (w_locked_s) w_state_nxt = QUALIFY;
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  assign w_state_chg  = (w_state_nxt != r_state);
  assign w_blink_wrap = (r_state == QUALIFY) ? (r_bcnt == FAST_LAST) : (r_bcnt == SLOW_LAST);
  assign w_cnt_base   = clr_count ? '0 : r_lost_cnt;

  always_ff @(posedge safe_clk or negedge safe_reset_n) begin
    if (!safe_reset_n) begin
      r_qcnt <= '0;
    end else if (w_state_chg) begin
      r_qcnt <= '0;
    end else if (r_state == QUALIFY && w_locked_s && r_qcnt != QCNT_LAST) begin
      r_qcnt <= r_qcnt + 1'b1;
    end
  end

  // Every blinking state starts lit with a fresh half-period.
  always_ff @(posedge safe_clk or negedge safe_reset_n) begin
    if (!safe_reset_n) begin
      r_bcnt <= '0;
      r_led  <= 1'b0;
    end else if (w_state_chg) begin
      r_bcnt <= '0;
      r_led  <= (w_state_nxt != WAIT_LOCK);
    end else if (r_state == QUALIFY || r_state == LOST) begin
      if (w_blink_wrap) begin
        r_bcnt <= '0;
        r_led  <= ~r_led;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge safe_clk or negedge safe_reset_n) begin
    if (!safe_reset_n) begin
      r_ever_locked <= 1'b0;
      r_lock_ok     <= 1'b0;
      r_lost_pulse  <= 1'b0;
      r_lost_cnt    <= '0;
    end else begin
      if (w_state_nxt == LOCKED) r_ever_locked <= 1'b1;
      r_lock_ok    <= (w_state_nxt == LOCKED);
      r_lost_pulse <= w_loss;
      if (w_loss) r_lost_cnt <= (w_cnt_base == LOST_CNT_MAX) ? LOST_CNT_MAX : w_cnt_base + 1'b1;
      else        r_lost_cnt <= w_cnt_base;
    end
  end

  assign lock_ok    = r_lock_ok;
  assign lost_pulse = r_lost_pulse;
  assign lost_count = r_lost_cnt;
  assign status_led = r_led;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_lock_monitor.sv
// tb/tb_lock_monitor.sv - directed and random checks of lock_monitor against a behavioural model
module tb_lock_monitor;

  localparam int SC = 8;
  localparam int BH = 8;

  logic       safe_clk = 1'b0;
  logic       safe_reset_n;
  logic       locked_async;
  logic       clr_count;
  logic       lock_ok;
  logic       lost_pulse;
  logic [7:0] lost_count;
  logic       status_led;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_bad = 0;
  int pulses = 0;

  // Reference model state: time spent in the current state drives both qualify and blink.
  int m_state, m_tin, m_ever, m_cnt, m_pulse, m_ok, m_h1, m_h2;

  lock_monitor #(.STABLE_CYCLES(SC), .BLINK_HALF(BH)) dut (
    .safe_clk     (safe_clk),
    .safe_reset_n (safe_reset_n),
    .locked_async (locked_async),
    .clr_count    (clr_count),
    .lock_ok      (lock_ok),
    .lost_pulse   (lost_pulse),
    .lost_count   (lost_count),
    .status_led   (status_led),
    .state_dbg    (state_dbg)
  );

  always #5 safe_clk = ~safe_clk;

  function automatic int led_of(input int s, input int t);
    case (s)
      1:       return ((t / (BH / 4)) % 2 == 0) ? 1 : 0;
      2:       return 1;
      3:       return ((t / BH) % 2 == 0) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_tin = 0; m_ever = 0; m_cnt = 0;
    m_pulse = 0; m_ok = 0; m_h1 = 0; m_h2 = 0;
  endtask

  task automatic model_step();
    int ls;
    int ns;
    int loss;
    if (safe_reset_n !== 1'b1) begin
      model_reset();
      return;
    end
    ls   = m_h2;
    m_h2 = m_h1;
    m_h1 = (locked_async === 1'b1) ? 1 : 0;
    ns   = m_state;
    case (m_state)
      0: ns = ls ? 1 : 0;
      1: ns = !ls ? (m_ever ? 3 : 0) : ((m_tin == SC - 1) ? 2 : 1);
      2: ns = ls ? 2 : 3;
      default: ns = ls ? 1 : 3;
    endcase
    loss = (m_state == 2 && !ls) ? 1 : 0;
    if (clr_count === 1'b1) m_cnt = 0;
    if (loss == 1 && m_cnt < 255) m_cnt = m_cnt + 1;
    m_tin   = (ns != m_state) ? 0 : m_tin + 1;
    if (ns == 2) m_ever = 1;
    m_state = ns;
    m_pulse = loss;
    m_ok    = (ns == 2) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state_dbg", {30'd0, state_dbg}, m_state);
    chk("lock_ok", {31'd0, lock_ok}, m_ok);
    chk("lost_pulse", {31'd0, lost_pulse}, m_pulse);
    chk("lost_count", {24'd0, lost_count}, m_cnt);
    chk("status_led", {31'd0, status_led}, led_of(m_state, m_tin));
  endtask

  task automatic tick();
    @(posedge safe_clk);
    model_step();
    #1;
    if (lost_pulse === 1'b1) pulses++;
    check_all();
    @(negedge safe_clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int bound, input string tag, output int n);
    n = 0;
    while (state_dbg !== s && n < bound) begin
      tick();
      n++;
    end
    chk(tag, {30'd0, state_dbg}, {30'd0, s});
  endtask

  task automatic force_loss(input string tag);
    int n;
    locked_async = 1'b1;
    wait_state(2'd2, 30, {tag, "_lock"}, n);
    locked_async = 1'b0;
    wait_state(2'd3, 10, {tag, "_lost"}, n);
  endtask

  initial begin
    int n;
    int p0;
    int seen_ok;
    int len;
    safe_reset_n = 1'b0;
    locked_async = 1'b0;
    clr_count    = 1'b0;
    model_reset();
    @(negedge safe_clk);
    tick();

    // Power-up lock with locked_async high from cycle 0
    locked_async = 1'b1;
    safe_reset_n = 1'b1;
    repeat (3) tick();
    chk("req033_state_c3", {30'd0, state_dbg}, 32'd1);
    repeat (8) tick();
    chk("req033_lock_ok_c11", {31'd0, lock_ok}, 32'd1);
    chk("req033_led_c11", {31'd0, status_led}, 32'd1);
    chk("req033_count", {24'd0, lost_count}, 32'd0);

    // Five-cycle dropout while locked, then relock
    p0 = pulses;
    locked_async = 1'b0;
    repeat (5) tick();
    locked_async = 1'b1;
    wait_state(2'd1, 20, "req034_requalify", n);
    wait_state(2'd2, 20, "req034_relock", n);
    chk("req034_relock_cycles", n, 32'd8);
    chk("req034_pulses", pulses - p0, 32'd1);
    chk("req034_count", {24'd0, lost_count}, 32'd1);

    // Abort qualification at counter 5 from a fresh reset
    safe_reset_n = 1'b0;
    tick();
    safe_reset_n = 1'b1;
    p0 = pulses;
    wait_state(2'd1, 20, "req035_qualify", n);
    repeat (3) tick();
    locked_async = 1'b0;
    seen_ok = 0;
    repeat (6) begin
      tick();
      if (lock_ok === 1'b1) seen_ok = 1;
    end
    chk("req035_state", {30'd0, state_dbg}, 32'd0);
    chk("req035_lock_ok_seen", seen_ok, 32'd0);
    chk("req035_pulses", pulses - p0, 32'd0);
    chk("req035_count", {24'd0, lost_count}, 32'd0);

    // Saturation of the loss counter
    p0 = pulses;
    for (int i = 0; i < 257; i++) force_loss("req036");
    chk("req036_saturated", {24'd0, lost_count}, 32'd255);
    chk("req036_pulses", pulses - p0, 32'd257);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("req036_cleared", {24'd0, lost_count}, 32'd0);

    // Clear coincident with a loss edge
    for (int i = 0; i < 7; i++) force_loss("req037_pre");
    chk("req037_count7", {24'd0, lost_count}, 32'd7);
    locked_async = 1'b1;
    wait_state(2'd2, 30, "req037_lock", n);
    locked_async = 1'b0;
    repeat (2) tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("req037_state", {30'd0, state_dbg}, 32'd3);
    chk("req037_count", {24'd0, lost_count}, 32'd1);

    // Asynchronous reset in LOST
    safe_reset_n = 1'b0;
    #1;
    model_reset();
    chk("req038_state", {30'd0, state_dbg}, 32'd0);
    chk("req038_lock_ok", {31'd0, lock_ok}, 32'd0);
    chk("req038_pulse", {31'd0, lost_pulse}, 32'd0);
    chk("req038_count", {24'd0, lost_count}, 32'd0);
    chk("req038_led", {31'd0, status_led}, 32'd0);
    tick();
    safe_reset_n = 1'b1;

    // Random lock activity against the model
    for (int seg = 0; seg < 400; seg++) begin
      locked_async = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 30));
      for (int k = 0; k < len; k++) begin
        clr_count = ($urandom_range(0, 31) == 0);
        tick();
      end
    end
    clr_count = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
